// File: rtl/gate_sensor_fsm.sv
// gate_sensor_fsm
// Decodes the direction of travel through the garage entrance lane from two infrared beams.
// A is the street-side beam and B is the garage-side beam.
// Each raw beam is synchronised, then debounced, then fed to a sequence FSM.
// A complete A->B passage gives a one-cycle car_in pulse.
// A complete B->A passage gives a one-cycle car_out pulse.
// An illegal sequence or a stalled sequence gives a one-cycle error pulse.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous active-low reset
//   sensor_a - raw beam A, 1 = blocked, asynchronous to clk
//   sensor_b - raw beam B, 1 = blocked, asynchronous to clk
//   car_in   - one-cycle pulse, completed entry
//   car_out  - one-cycle pulse, completed exit
//   error    - one-cycle pulse, illegal sequence or timeout
//   state    - current FSM state, for debug and LEDs
module gate_sensor_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic       car_in,
    output logic       car_out,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StInA     = 3'b001,
        StInAb    = 3'b010,
        StInB     = 3'b011,
        StOutB    = 3'b100,
        StOutBa   = 3'b101,
        StOutA    = 3'b110,
        StWaitClr = 3'b111
    } state_e;

    // A counter that reaches its last value this cycle completes the count on this edge.
    localparam logic [7:0]  DbLast = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);

    // Bit 0 carries beam A and bit 1 carries beam B.
    logic [1:0]      meta_q, sync_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0][7:0] db_cnt_q, db_cnt_d;
    logic [15:0]     tmr_q, tmr_d;
    state_e          state_q, state_d;
    logic            car_in_q, car_in_d;
    logic            car_out_q, car_out_d;
    logic            error_q, error_d;
    logic            a, b, timed_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {sensor_b, sensor_a};
            sync_q <= meta_q;
        end
    end

    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign a         = deb_q[0];
    assign b         = deb_q[1];
    assign timed_out = (tmr_q == ToLast);

    always_comb begin
        state_d   = state_q;
        car_in_d  = 1'b0;
        car_out_d = 1'b0;
        error_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (a && !b) begin
                    state_d = StInA;
                end else if (!a && b) begin
                    state_d = StOutB;
                end else if (a && b) begin
                    state_d = StWaitClr;
                    error_d = 1'b1;
                end
            end
            StInA: begin
                if (a && b) begin
                    state_d = StInAb;
                end else if (!a && !b) begin
                    state_d = StIdle;
                end else if ((!a && b) || timed_out) begin
                    state_d = StWaitClr;
                    error_d = 1'b1;
                end
            end
            StInAb: begin
                if (!a && b) begin
                    state_d = StInB;
                end else if (a && !b) begin
                    state_d = StInA;
                end else if (!a && !b) begin
                    state_d = StIdle;
                    error_d = 1'b1;
                end else if (timed_out) begin
                    state_d = StWaitClr;
                    error_d = 1'b1;
                end
            end
            StInB: begin
                if (!a && !b) begin
                    state_d  = StIdle;
                    car_in_d = 1'b1;
                end else if (a && b) begin
                    state_d = StInAb;
                end else if ((a && !b) || timed_out) begin
                    state_d = StWaitClr;
                    error_d = 1'b1;
                end
            end
            StOutB: begin
                if (a && b) begin
                    state_d = StOutBa;
                end else if (!a && !b) begin
                    state_d = StIdle;
                end else if ((a && !b) || timed_out) begin
                    state_d = StWaitClr;
                    error_d = 1'b1;
                end
            end
            StOutBa: begin
                if (a && !b) begin
                    state_d = StOutA;
                end else if (!a && b) begin
                    state_d = StOutB;
                end else if (!a && !b) begin
                    state_d = StIdle;
                    error_d = 1'b1;
                end else if (timed_out) begin
                    state_d = StWaitClr;
                    error_d = 1'b1;
                end
            end
            StOutA: begin
                if (!a && !b) begin
                    state_d   = StIdle;
                    car_out_d = 1'b1;
                end else if (a && b) begin
                    state_d = StOutBa;
                end else if ((!a && b) || timed_out) begin
                    state_d = StWaitClr;
                    error_d = 1'b1;
                end
            end
            StWaitClr: begin
                if (!a && !b) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Every timeout forces a state change, so the timer can never run past ToLast.
    always_comb begin
        tmr_d = tmr_q + 16'd1;
        if (state_d != state_q || deb_d != deb_q ||
            state_q == StIdle || state_q == StWaitClr) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q     <= '0;
            db_cnt_q  <= '0;
            tmr_q     <= '0;
            state_q   <= StIdle;
            car_in_q  <= 1'b0;
            car_out_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            db_cnt_q  <= db_cnt_d;
            tmr_q     <= tmr_d;
            state_q   <= state_d;
            car_in_q  <= car_in_d;
            car_out_q <= car_out_d;
            error_q   <= error_d;
        end
    end

    assign car_in  = car_in_q;
    assign car_out = car_out_q;
    assign error   = error_q;
    assign state   = state_q;

endmodule

// File: tb/tb_gate_sensor_fsm.sv
// Bench for gate_sensor_fsm with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=16.
// Table steps drive a raw sensor level for a number of cycles.
// Each step pushes its expectation onto a scoreboard queue.
// When the step's window ends, the expectation is popped and compared with the DUT.
// Pulse counts come from a monitor that runs on the falling edge.
module tb_gate_sensor_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_a;
    logic       sensor_b;
    logic       car_in;
    logic       car_out;
    logic       error;
    logic [2:0] state;

    gate_sensor_fsm #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sensor_a(sensor_a),
        .sensor_b(sensor_b),
        .car_in  (car_in),
        .car_out (car_out),
        .error   (error),
        .state   (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic     sa;
        logic     sb;
        int       cycles;
        int       st;
        int       n_in;
        int       n_out;
        int       n_err;
    } step_t;

    step_t vec[$];
    step_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    // Monitor-owned running totals; the stimulus side only reads them.
    int tot_in = 0, tot_out = 0, tot_err = 0, excl = 0;

    always @(negedge clk) begin
        if (car_in === 1'b1)  tot_in++;
        if (car_out === 1'b1) tot_out++;
        if (error === 1'b1)   tot_err++;
        if (int'(car_in) + int'(car_out) + int'(error) > 1) excl++;
    end

    function automatic step_t mk(string name, logic sa, logic sb, int cycles, int st,
                                 int n_in, int n_out, int n_err);
        step_t s;
        s.name = name; s.sa = sa; s.sb = sb; s.cycles = cycles; s.st = st;
        s.n_in = n_in; s.n_out = n_out; s.n_err = n_err;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step_t s;
            int b_in, b_out, b_err;
            b_in = tot_in; b_out = tot_out; b_err = tot_err;
            sensor_a = vec[i].sa;
            sensor_b = vec[i].sb;
            sb_q.push_back(vec[i]);
            repeat (vec[i].cycles) tick();
            s = sb_q.pop_front();
            check({s.name, "_state"}, int'(state), s.st);
            check({s.name, "_car_in"}, tot_in - b_in, s.n_in);
            check({s.name, "_car_out"}, tot_out - b_out, s.n_out);
            check({s.name, "_error"}, tot_err - b_err, s.n_err);
        end
    endtask

    initial begin
        int n;
        int b_in, b_out, b_err;

        // 0-2: entry up to IN_B
        vec.push_back(mk("entry_a",    1, 0, 10, 1, 0, 0, 0));
        vec.push_back(mk("entry_ab",   1, 1, 10, 2, 0, 0, 0));
        vec.push_back(mk("entry_b",    0, 1, 10, 3, 0, 0, 0));
        // 3-8: exit with a 2-cycle glitch on A while in OUT_B
        vec.push_back(mk("exit_b",     0, 1,  8, 4, 0, 0, 0));
        vec.push_back(mk("glitch_on",  1, 1,  2, 4, 0, 0, 0));
        vec.push_back(mk("glitch_off", 0, 1,  3, 4, 0, 0, 0));
        vec.push_back(mk("exit_ba",    1, 1, 10, 5, 0, 0, 0));
        vec.push_back(mk("exit_a",     1, 0, 10, 6, 0, 0, 0));
        vec.push_back(mk("exit_done",  0, 0, 10, 0, 0, 1, 0));
        // 9-10: back-out
        vec.push_back(mk("back_a",     1, 0, 10, 1, 0, 0, 0));
        vec.push_back(mk("back_clr",   0, 0, 10, 0, 0, 0, 0));
        // 11-15: simultaneous rise from IDLE, then A->B swap from IN_A
        vec.push_back(mk("simul",      1, 1, 10, 7, 0, 0, 1));
        vec.push_back(mk("simul_clr",  0, 0, 10, 0, 0, 0, 0));
        vec.push_back(mk("swap_a",     1, 0, 10, 1, 0, 0, 0));
        vec.push_back(mk("swap_b",     0, 1, 10, 7, 0, 0, 1));
        vec.push_back(mk("swap_clr",   0, 0, 10, 0, 0, 0, 0));
        // 16-18: reach IN_B before the mid-sequence reset
        vec.push_back(mk("rst_a",      1, 0, 10, 1, 0, 0, 0));
        vec.push_back(mk("rst_ab",     1, 1, 10, 2, 0, 0, 0));
        vec.push_back(mk("rst_b",      0, 1, 10, 3, 0, 0, 0));

        reset = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",   int'(state),   0);
        check("reset_car_in",  int'(car_in),  0);
        check("reset_car_out", int'(car_out), 0);
        check("reset_error",   int'(error),   0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();

        // Normal entry: the car_in pulse lands 6 edges after the first edge that samples B=0.
        run_range(0, 2);
        b_in = tot_in; b_out = tot_out; b_err = tot_err;
        sensor_b = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (car_in === 1'b1) break;
        end
        check("entry_car_in_latency", n, 1 + 6);
        repeat (10) tick();
        check("entry_done_state", int'(state), 0);
        check("entry_done_car_in", tot_in - b_in, 1);
        check("entry_done_car_out", tot_out - b_out, 0);
        check("entry_done_error", tot_err - b_err, 0);

        run_range(3, 15);

        // Timeout: error arrives 16 edges after IN_A is entered.
        b_in = tot_in; b_out = tot_out; b_err = tot_err;
        sensor_a = 1'b1;
        n = 0;
        while (n < 40 && state !== 3'b001) begin
            tick();
            n++;
        end
        check("timeout_enter_in_a", int'(state), 1);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (error === 1'b1) break;
        end
        check("timeout_latency", n, 16);
        check("timeout_state", int'(state), 7);
        repeat (10) tick();
        check("timeout_hold_state", int'(state), 7);
        sensor_a = 1'b0;
        repeat (10) tick();
        check("timeout_clr_state", int'(state), 0);
        check("timeout_error_count", tot_err - b_err, 1);
        check("timeout_car_in", tot_in - b_in, 0);
        check("timeout_car_out", tot_out - b_out, 0);

        // Reset mid-sequence from IN_B: partial passage discarded.
        run_range(16, 18);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_state",   int'(state),   0);
        check("midrst_car_in",  int'(car_in),  0);
        check("midrst_error",   int'(error),   0);
        b_in = tot_in; b_err = tot_err;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (30) tick();
        check("midrst_after_state", int'(state), 0);
        check("midrst_after_car_in", tot_in - b_in, 0);
        check("midrst_after_error", tot_err - b_err, 0);

        check("exclusive_outputs", excl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sensor_fsm.md
# gate_sensor_fsm

Direction-decoding front end for the garage entrance lane, directly upstream of the occupancy counter. Two raw infrared beam sensors (A = street side, B = garage side) are synchronised, debounced and run through a sequence state machine. Each complete A→B passage produces a single-cycle `car_in` pulse and each complete B→A passage produces a single-cycle `car_out` pulse. Those pulses drive the counter's `car_in` / `car_out` inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a new sensor level must hold before it is accepted; range 1..255.
- `TIMEOUT_CYCLES`, 1000: maximum cycles a sequence may sit with no debounced input change; range 2..65535.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `sensor_a` input 1: raw beam A, 1 = blocked; asynchronous to `clk`.
- `sensor_b` input 1: raw beam B, 1 = blocked; asynchronous to `clk`.
- `car_in` output 1: one-cycle pulse, completed entry.
- `car_out` output 1: one-cycle pulse, completed exit.
- `error` output 1: one-cycle pulse, illegal sequence or timeout.
- `state` output 3: current FSM state, for debug and LEDs.

## Operation
- **Synchronisers:** 2-flop synchroniser per sensor.
- **Debounce:** one counter per sensor.
  - The counter clears whenever the synced value equals the debounced value.
  - Otherwise it increments.
  - On reaching `DEBOUNCE_CYCLES` the debounced value takes the synced value and the counter clears.
- **FSM states** (binary encoding): IDLE=000, IN_A=001, IN_AB=010, IN_B=011, OUT_B=100, OUT_BA=101, OUT_A=110, WAIT_CLR=111. Inputs are the debounced values a and b.
- **IDLE:**
  - a&!b → IN_A
  - !a&b → OUT_B
  - a&b → WAIT_CLR, with `error`
- **IN_A:**
  - a&b → IN_AB
  - !a&!b → IDLE (car backed out, no pulse)
  - !a&b → WAIT_CLR, with `error`
- **IN_AB:**
  - !a&b → IN_B
  - a&!b → IN_A
  - !a&!b → IDLE, with `error`
- **IN_B:**
  - !a&!b → IDLE, with `car_in`
  - a&b → IN_AB
  - a&!b → WAIT_CLR, with `error`
- **OUT_B, OUT_BA, OUT_A:** mirror of IN_A, IN_AB, IN_B with a and b swapped. OUT_A → IDLE on !a&!b asserts `car_out`.
- **WAIT_CLR:** stays until !a&!b, then → IDLE with no pulse. No timeout applies in this state.
- **Timeout:**
  - A 16-bit idle counter runs in every state except IDLE and WAIT_CLR.
  - It clears on any state change or any debounced input change.
  - On reaching `TIMEOUT_CYCLES` the FSM → WAIT_CLR with `error`.
- **Output exclusivity:** at most one of `car_in`, `car_out`, `error` is high in any cycle. Pulses are always exactly one cycle wide.
- **Unchanged inputs:** in any state where the debounced inputs are unchanged, the FSM stays put.

## Timing
- **Reset** (asynchronous, `reset`=0): all outputs and internal state clear immediately.
  - `state`=000; `car_in`, `car_out`, `error` = 0.
  - Synchroniser flops, debounced values, debounce counters and timeout counter = 0.
- **Reset mid-sequence:** the partial passage is discarded and no pulse is produced.
- **Leaving reset:** if a sensor is already blocked at release, it is debounced normally, and IDLE with a&b goes to WAIT_CLR with `error`.
- **Input latency:** a raw level first sampled at edge k appears synced after edge k+1. The debounced value updates at edge k+1+`DEBOUNCE_CYCLES`. The FSM transitions at the following edge.
- **Outputs:** `car_in`, `car_out`, `error` and `state` are registered and change on the same edge as the transition.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` synced cycles is never seen by the FSM.
- **Throughput:** back-to-back passages are fully supported. A new sequence may begin on the cycle after IDLE is re-entered.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=16.

- **Normal entry:** A=1; then B=1; then A=0; then B=0, 10 cycles apart → states 001, 010, 011, 000, and exactly one `car_in` pulse 6 cycles after B falls. `car_out` and `error` stay 0.
- **Normal exit plus glitch rejection:** full B→A passage with 2-cycle glitches injected on A while in OUT_B → exactly one `car_out`. The glitches cause no state change.
- **Back-out:** A=1 for 10 cycles, then A=0 → 001 then 000. No pulses.
- **Timeout:** A=1 and held → `error` pulses once 16 cycles after entering IN_A, `state`=111. Releasing A → 000 with no further pulse.
- **Simultaneous / illegal:** A and B rising on the same cycle from IDLE → one `error` pulse, then WAIT_CLR until both clear. In IN_A, drop A while raising B → one `error` pulse.
- **Reset mid-operation:** assert `reset` low while in IN_B → `state`=000 immediately. After release with sensors clear, no `car_in` ever appears.
